// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product consumer: reduces each product, applies the
// sign-extension correction and accumulates N_TERMS products per output word.
`timescale 1ns/1ps
module booth_pp_accumulator #(
  parameter int N_TERMS = 9,
  parameter int ACC_W   = 19,
  parameter int CORR    = -45056
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      pp0,
  input  logic [9:0]       pp1,
  input  logic [9:0]       pp2,
  input  logic [9:0]       pp3,
  input  logic             neg0,
  input  logic             neg1,
  input  logic             neg2,
  input  logic             neg3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);
  localparam logic [ACC_W-1:0] CORR_X = ACC_W'(CORR);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_last_q, s1_last_d;
  logic [ACC_W-1:0] s1_term_q, s1_term_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_vld_q, out_vld_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] sum;
  logic [6:0]       negs;
  logic             stall;
  logic             accept;

  assign negs = {neg3, 1'b0, neg2, 1'b0, neg1, 1'b0, neg0};

  assign term = ACC_W'(pp0)
              + (ACC_W'(pp1) << 2)
              + (ACC_W'(pp2) << 4)
              + (ACC_W'(pp3) << 6)
              + ACC_W'(negs)
              + CORR_X;

  // Only a last term blocked by an unaccepted result backs up the pipe.
  assign stall  = out_vld_q & ~out_ready & s1_vld_q & s1_last_q;
  assign accept = in_valid & ~stall;
  assign sum    = acc_q + s1_term_q;

  always_comb begin
    cnt_d      = cnt_q;
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s1_term_d  = s1_term_q;
    acc_d      = acc_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;

    if (!stall) begin
      s1_vld_d  = accept;
      s1_last_d = accept && (cnt_q == LAST_CNT);
      if (accept) begin
        s1_term_d = term;
      end
    end

    if (accept) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end

    if (out_vld_q && out_ready) begin
      out_vld_d = 1'b0;
    end

    if (s1_vld_q && !stall) begin
      if (s1_last_q) begin
        out_data_d = sum;
        out_vld_d  = 1'b1;
        acc_d      = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_term_q  <= '0;
      acc_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_term_q  <= s1_term_d;
      acc_q      <= acc_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign busy      = (cnt_q != '0) | s1_vld_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator; operands go through a Booth
// partial-product generator model, results are checked against sums of a*b.
`timescale 1ns/1ps
module tb_booth_pp_accumulator;

  localparam int AW = 19;
  localparam int NT = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   pp0;
  logic [9:0]    pp1, pp2, pp3;
  logic          neg0, neg1, neg2, neg3;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int mdl_sum = 0;
  int mdl_cnt = 0;
  int expq[$];
  int w;

  always #5 clk = ~clk;

  booth_pp_accumulator #(.N_TERMS(NT), .ACC_W(AW), .CORR(-45056)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dv(input int v);
    logic [AW-1:0] t;
    t = AW'(v);
    return 32'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Radix-4 Booth PPG: rows {~s,s,s,X} and {~s,X}, negatives as ~m plus neg.
  task automatic ppg(input int a, input int b);
    logic [8:0]  bb;
    logic [8:0]  x[4];
    logic [3:0]  ng;
    int d, m, xi;
    bb = {b[7:0], 1'b0};
    for (int i = 0; i < 4; i++) begin
      d = -2 * int'(bb[2*i+2]) + int'(bb[2*i+1]) + int'(bb[2*i]);
      m = (d < 0 ? -d : d) * a;
      xi = (d < 0) ? -m - 1 : m;
      ng[i] = (d < 0);
      x[i] = xi[8:0];
    end
    pp0 = {~x[0][8], x[0][8], x[0][8], x[0]};
    pp1 = {~x[1][8], x[1]};
    pp2 = {~x[2][8], x[2]};
    pp3 = {~x[3][8], x[3]};
    {neg3, neg2, neg1, neg0} = ng;
  endtask

  task automatic send(input int a, input int b, output int waits);
    ppg(a, b);
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      chk("send_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      mdl_sum += a * b;
      mdl_cnt++;
      if (mdl_cnt == NT) begin
        expq.push_back(mdl_sum);
        mdl_sum = 0;
        mdl_cnt = 0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_pending", 32'(expq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        chk("result", 32'(out_data), dv(expq.pop_front()));
      end
    end
  end

  int alist[16] = '{-128, -127, -100, -64, -33, -17, -2, -1,
                    0, 1, 2, 15, 37, 64, 126, 127};

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ppg(0, 0);
    tick();
    tick();
    reset = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: latency of the first group
    for (int i = 0; i < NT; i++) send(3, -5, w);
    chk("t1_lat_early", 32'(out_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_lat", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), dv(-135));

    // 2: extreme products, back to back
    for (int i = 0; i < NT; i++) send(-128, -128, w);
    for (int i = 0; i < NT; i++) send(-128, 127, w);
    drain();

    // 3: output hold while a second group completes
    out_ready = 1'b0;
    for (int i = 0; i < NT; i++) send(2, 3, w);
    tick();
    tick();
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data", 32'(out_data), dv(54));
    for (int i = 0; i < NT; i++) begin
      send(-7, 11, w);
      chk("t3_no_early_stall", 32'(w), 32'd0);
    end
    chk("t3_stall_ready", 32'(in_ready), 32'd0);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_data", 32'(out_data), dv(54));
      chk("t3_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain();

    // 4: reset in the middle of a group
    for (int i = 0; i < 4; i++) send(100, 100, w);
    chk("t4_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mdl_sum = 0;
    mdl_cnt = 0;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_data", 32'(out_data), 32'd0);
    for (int i = 0; i < NT; i++) send(1, 1, w);
    drain();

    // 5: three groups with random input gaps, mixed terms
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < NT; i++) begin
        case (g)
          0: send(5, -9, w);
          1: send(-100 + 25 * i, 77 - 19 * i, w);
          default: send(127, 127, w);
        endcase
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    drain();

    // 6: operand sweep, every b against a spread of a values
    for (int ia = 0; ia < 16; ia++) begin
      for (int b = -128; b < 128; b++) begin
        for (int i = 0; i < NT; i++) send(alist[ia], b, w);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
